path_trace: RTL and testbench
=============================

Name: path_trace

Overview:
- Reader side of the per-node cost/direction field produced by the node-execution array.
- After the relaxation sweep settles, path_trace starts at a destination cell and repeatedly reads that cell's (cost, dir). It follows dir to the predecessor until it reaches the source cell, where cost is 0.
- Emits the visited cells as a valid/ready coordinate stream, destination first, source last.
- Sits between the grid's read mux and the path consumer (motion controller / host FIFO).

Parameters:
- GRID_W, 16, grid width in cells; x range 0..GRID_W-1.
- GRID_H, 16, grid height in cells; y range 0..GRID_H-1.
- XW, 4, x coordinate width; must satisfy 2^XW >= GRID_W.
- YW, 4, y coordinate width; must satisfy 2^YW >= GRID_H.
- MAX_STEPS, 256, cap on emitted cells (loop guard); default GRID_W*GRID_H.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin trace; ignored unless idle.
- abort  in  1  synchronous abort; highest priority after reset.
- dst_x  in  XW  destination x; sampled on accepted start.
- dst_y  in  YW  destination y; sampled on accepted start.
- rd_en  out  1  read request for cell (rd_x, rd_y); one-cycle pulse.
- rd_x  out  XW  read x; held until rd_valid.
- rd_y  out  YW  read y; held until rd_valid.
- rd_valid  in  1  read data valid, 1 or more cycles after rd_en.
- rd_cost  in  12  path_cost of the addressed cell.
- rd_dir  in  3  path_dir of the addressed cell.
- step_valid  out  1  step stream valid.
- step_ready  in  1  step stream ready.
- step_x  out  XW  emitted cell x.
- step_y  out  YW  emitted cell y.
- step_last  out  1  marks the source cell (final beat).
- busy  out  1  high from accepted start until done/err/abort.
- done  out  1  one-cycle pulse; trace completed.
- err  out  1  one-cycle pulse; trace failed.
- err_code  out  2  0 none, 1 unreached, 2 off-grid, 3 loop/over-length; held until next start.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Direction encoding (index of predecessor neighbour): 0 N (y-1), 1 NE (x+1, y-1), 2 E (x+1), 3 SE (x+1, y+1), 4 S (y+1), 5 SW (x-1, y+1), 6 W (x-1), 7 NW (x-1, y-1).
- FSM states and transitions:
  - IDLE: start && !abort -> latch cur=(dst_x, dst_y), steps=0, prev_cost=12'hFFF, busy=1 -> FETCH.
  - FETCH: drive rd_x/rd_y=cur, pulse rd_en for one cycle -> WAIT.
  - WAIT: hold rd_x/rd_y. On rd_valid, capture cost and dir, then:
    - cost==12'hFFF -> ERR code 1.
    - cost >= prev_cost and steps != 0 -> ERR code 3.
    - otherwise -> EMIT.
  - EMIT: step_valid=1, step_x/y=cur, step_last=(cost==0). Payload is stable while valid && !ready. On valid && ready: steps++.
    - If last -> DONE.
    - Else if steps+1 == MAX_STEPS -> ERR code 3.
    - Else compute next cell from dir. Next cell out of grid -> ERR code 2. Otherwise cur=next, prev_cost=cost -> FETCH.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
  - ERR: err=1 for one cycle, busy=0, err_code latched -> IDLE.
- Bounds rule: x-1 at x=0, x+1 at GRID_W-1, and the same for y are off-grid. There is no wrap-around.
- Minimum per-cell latency with rd_valid one cycle after rd_en and ready held high: 3 cycles (FETCH, WAIT, EMIT).
- A destination with cost 0 emits one beat with step_last=1, then pulses done.
- start while busy: ignored, no side effects.
- abort (any state except IDLE): next cycle IDLE, step_valid=0, busy=0, no done/err pulse. A late rd_valid after abort is ignored.
- start and abort in the same cycle: abort wins; start is dropped.
- Reset mid-trace: immediate return to reset values.
- The cost comparison is unsigned 12-bit. Strict decrease guarantees termination even with corrupted dir fields.

Decomposition:
- Shared package path_pkg: COST_W=12; COST_INF=12'hFFF; direction constants DIR_N..DIR_NW (3-bit); err_code constants ERR_NONE, ERR_UNREACHED, ERR_OFFGRID, ERR_LOOP.
- One combinational sub-module, path_dir_step: inputs cur x/y and dir; outputs next x/y and off_grid flag; parameterised by GRID_W/GRID_H.

Test Plan:
- Straight path: dst (5,0); cells (5,0)..(1,0) have dir=6 (W) and costs 10,8,6,4,2; (0,0) has cost 0. Ready held high -> beats (5,0),(4,0),(3,0),(2,0),(1,0),(0,0); last only on (0,0); done pulse; busy low the next cycle.
- Diagonal plus backpressure: dst (3,3) dir=7 cost 9; (2,2) dir=7 cost 6; (1,1) dir=7 cost 3; (0,0) cost 0. step_ready toggles every other cycle -> 4 beats with payload stable while stalled; no duplicated or lost beats.
- Unreached: dst (7,7) with rd_cost=12'hFFF -> zero beats; err pulse with err_code=1.
- Off-grid: dst (0,4) cost 5 dir=6 (W) -> one beat (0,4), then err with err_code=2.
- Loop guard: (2,2) dir=2 cost 5 and (3,2) dir=6 cost 5 -> beat (2,2) then (3,2)? No: the second read fails strict decrease, so only beat (2,2) is emitted, then err with err_code=3.
- Control edges:
  - start pulsed while busy -> no effect.
  - abort while waiting on rd_valid, with rd_valid arriving one cycle later -> idle, no done/err, no beat.
  - rst_n asserted mid-EMIT -> step_valid=0 immediately.

Source files
------------

// File: rtl/path_pkg.sv
// Shared constants and state encoding for the path trace reader.
package path_pkg;

    localparam int COST_W = 12;
    localparam logic [COST_W-1:0] COST_INF = 12'hFFF;

    localparam logic [2:0] DIR_N  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_E  = 3'd2;
    localparam logic [2:0] DIR_SE = 3'd3;
    localparam logic [2:0] DIR_S  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_W  = 3'd6;
    localparam logic [2:0] DIR_NW = 3'd7;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNREACHED = 2'd1;
    localparam logic [1:0] ERR_OFFGRID   = 2'd2;
    localparam logic [1:0] ERR_LOOP      = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

endpackage

// File: rtl/path_dir_step.sv
// Predecessor-cell calculator: applies a direction code to a cell and flags
// steps that leave the grid (no wrap-around).
module path_dir_step
    import path_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int XW     = 4,
    parameter int YW     = 4
) (
    input  logic [XW-1:0] cur_x,
    input  logic [YW-1:0] cur_y,
    input  logic [2:0]    dir,
    output logic [XW-1:0] nxt_x,
    output logic [YW-1:0] nxt_y,
    output logic          off_grid
);

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 32'sd1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 32'sd1);
    localparam logic [XW-1:0] X_ONE = XW'(1'b1);
    localparam logic [YW-1:0] Y_ONE = YW'(1'b1);

    logic inc_x_s, dec_x_s, inc_y_s, dec_y_s;
    logic off_x_s, off_y_s;

    // Decode direction into per-axis increment/decrement requests.
    always_comb begin
        inc_x_s = 1'b0;
        dec_x_s = 1'b0;
        inc_y_s = 1'b0;
        dec_y_s = 1'b0;
        case (dir)
            DIR_N:   dec_y_s = 1'b1;
            DIR_NE:  begin inc_x_s = 1'b1; dec_y_s = 1'b1; end
            DIR_E:   inc_x_s = 1'b1;
            DIR_SE:  begin inc_x_s = 1'b1; inc_y_s = 1'b1; end
            DIR_S:   inc_y_s = 1'b1;
            DIR_SW:  begin dec_x_s = 1'b1; inc_y_s = 1'b1; end
            DIR_W:   dec_x_s = 1'b1;
            DIR_NW:  begin dec_x_s = 1'b1; dec_y_s = 1'b1; end
            default: begin inc_x_s = 1'b0; dec_x_s = 1'b0; end
        endcase
    end

    // Apply the x and y moves with edge detection.
    always_comb begin
        nxt_x   = cur_x;
        nxt_y   = cur_y;
        off_x_s = 1'b0;
        off_y_s = 1'b0;
        if (dec_x_s) begin
            off_x_s = (cur_x == {XW{1'b0}});
            nxt_x   = cur_x - X_ONE;
        end else if (inc_x_s) begin
            off_x_s = (cur_x >= X_MAX);
            nxt_x   = cur_x + X_ONE;
        end else begin
            off_x_s = 1'b0;
            nxt_x   = cur_x;
        end
        if (dec_y_s) begin
            off_y_s = (cur_y == {YW{1'b0}});
            nxt_y   = cur_y - Y_ONE;
        end else if (inc_y_s) begin
            off_y_s = (cur_y >= Y_MAX);
            nxt_y   = cur_y + Y_ONE;
        end else begin
            off_y_s = 1'b0;
            nxt_y   = cur_y;
        end
        off_grid = off_x_s | off_y_s;
    end

endmodule

// File: rtl/path_trace.sv
// Walks the settled cost/direction field from a destination back to the
// source, streaming each visited cell as a valid/ready beat.
module path_trace
    import path_pkg::*;
#(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 16,
    parameter int XW        = 4,
    parameter int YW        = 4,
    parameter int MAX_STEPS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [XW-1:0]     dst_x,
    input  logic [YW-1:0]     dst_y,
    output logic              rd_en,
    output logic [XW-1:0]     rd_x,
    output logic [YW-1:0]     rd_y,
    input  logic              rd_valid,
    input  logic [COST_W-1:0] rd_cost,
    input  logic [2:0]        rd_dir,
    output logic              step_valid,
    input  logic              step_ready,
    output logic [XW-1:0]     step_x,
    output logic [YW-1:0]     step_y,
    output logic              step_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1'b1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 32'sd1);

    state_e              state_r, state_next_s;
    logic [XW-1:0]       cur_x_r, cur_x_next_s, nxt_x_s;
    logic [YW-1:0]       cur_y_r, cur_y_next_s, nxt_y_s;
    logic [STEP_W-1:0]   steps_r, steps_next_s;
    logic [COST_W-1:0]   prev_cost_r, prev_cost_next_s;
    logic [COST_W-1:0]   cost_r, cost_next_s;
    logic [2:0]          dir_r, dir_next_s;
    logic [1:0]          err_code_r, err_code_next_s;
    logic                off_grid_s;
    logic                rd_en_r, step_valid_r, step_last_r, busy_r, done_r, err_r;

    path_dir_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW)
    ) u_dir_step (
        .cur_x    (cur_x_r),
        .cur_y    (cur_y_r),
        .dir      (dir_r),
        .nxt_x    (nxt_x_s),
        .nxt_y    (nxt_y_s),
        .off_grid (off_grid_s)
    );

    // Next-state and datapath update logic; abort overrides every busy state.
    always_comb begin
        state_next_s     = state_r;
        cur_x_next_s     = cur_x_r;
        cur_y_next_s     = cur_y_r;
        steps_next_s     = steps_r;
        prev_cost_next_s = prev_cost_r;
        cost_next_s      = cost_r;
        dir_next_s       = dir_r;
        err_code_next_s  = err_code_r;
        if (abort && (state_r != S_IDLE)) begin
            state_next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_next_s     = S_FETCH;
                        cur_x_next_s     = dst_x;
                        cur_y_next_s     = dst_y;
                        steps_next_s     = {STEP_W{1'b0}};
                        prev_cost_next_s = COST_INF;
                        err_code_next_s  = ERR_NONE;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end
                S_FETCH: state_next_s = S_WAIT;
                S_WAIT: begin
                    if (rd_valid) begin
                        cost_next_s = rd_cost;
                        dir_next_s  = rd_dir;
                        if (rd_cost == COST_INF) begin
                            state_next_s    = S_ERR;
                            err_code_next_s = ERR_UNREACHED;
                        end else if ((rd_cost >= prev_cost_r) && (steps_r != {STEP_W{1'b0}})) begin
                            state_next_s    = S_ERR;
                            err_code_next_s = ERR_LOOP;
                        end else begin
                            state_next_s = S_EMIT;
                        end
                    end else begin
                        state_next_s = S_WAIT;
                    end
                end
                S_EMIT: begin
                    if (step_ready) begin
                        steps_next_s = steps_r + STEP_ONE;
                        if (cost_r == {COST_W{1'b0}}) begin
                            state_next_s = S_DONE;
                        end else if (steps_r == STEP_LAST) begin
                            state_next_s    = S_ERR;
                            err_code_next_s = ERR_LOOP;
                        end else if (off_grid_s) begin
                            state_next_s    = S_ERR;
                            err_code_next_s = ERR_OFFGRID;
                        end else begin
                            state_next_s     = S_FETCH;
                            cur_x_next_s     = nxt_x_s;
                            cur_y_next_s     = nxt_y_s;
                            prev_cost_next_s = cost_r;
                        end
                    end else begin
                        state_next_s = S_EMIT;
                    end
                end
                S_DONE:  state_next_s = S_IDLE;
                S_ERR:   state_next_s = S_IDLE;
                default: state_next_s = S_IDLE;
            endcase
        end
    end

    // State, datapath and registered output flags (outputs follow the next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            cur_x_r      <= {XW{1'b0}};
            cur_y_r      <= {YW{1'b0}};
            steps_r      <= {STEP_W{1'b0}};
            prev_cost_r  <= COST_INF;
            cost_r       <= {COST_W{1'b0}};
            dir_r        <= 3'd0;
            err_code_r   <= ERR_NONE;
            rd_en_r      <= 1'b0;
            step_valid_r <= 1'b0;
            step_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cur_x_r      <= cur_x_next_s;
            cur_y_r      <= cur_y_next_s;
            steps_r      <= steps_next_s;
            prev_cost_r  <= prev_cost_next_s;
            cost_r       <= cost_next_s;
            dir_r        <= dir_next_s;
            err_code_r   <= err_code_next_s;
            rd_en_r      <= (state_next_s == S_FETCH);
            step_valid_r <= (state_next_s == S_EMIT);
            step_last_r  <= (state_next_s == S_EMIT) && (cost_next_s == {COST_W{1'b0}});
            busy_r       <= (state_next_s == S_FETCH) || (state_next_s == S_WAIT) ||
                            (state_next_s == S_EMIT);
            done_r       <= (state_next_s == S_DONE);
            err_r        <= (state_next_s == S_ERR);
        end
    end

    assign rd_en      = rd_en_r;
    assign rd_x       = cur_x_r;
    assign rd_y       = cur_y_r;
    assign step_valid = step_valid_r;
    assign step_x     = cur_x_r;
    assign step_y     = cur_y_r;
    assign step_last  = step_last_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign err_code   = err_code_r;

endmodule

// File: tb/tb_path_trace.sv
// Directed bench for path_trace: grid memory model, beat scoreboard queue and
// immediate-assertion checks.
module tb_path_trace;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [3:0]  dst_x, dst_y;
    logic        rd_en, rd_valid;
    logic [3:0]  rd_x, rd_y;
    logic [11:0] rd_cost;
    logic [2:0]  rd_dir;
    logic        step_valid, step_ready, step_last;
    logic [3:0]  step_x, step_y;
    logic        busy, done, err;
    logic [1:0]  err_code;

    logic [11:0] cost_mem [0:15][0:15];
    logic [2:0]  dir_mem  [0:15][0:15];
    logic [8:0]  sb_q [$];
    int          tests = 0;
    int          fails = 0;
    int          rd_lat = 1;
    int          ready_mode = 0;

    path_trace dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dst_x(dst_x), .dst_y(dst_y),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_valid(rd_valid), .rd_cost(rd_cost), .rd_dir(rd_dir),
        .step_valid(step_valid), .step_ready(step_ready),
        .step_x(step_x), .step_y(step_y), .step_last(step_last),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                cost_mem[x][y] = 12'hFFF;
                dir_mem[x][y]  = 3'd0;
            end
        end
    endtask

    task automatic push_beat(input logic [3:0] x, input logic [3:0] y, input logic last);
        sb_q.push_back({x, y, last});
    endtask

    task automatic kick(input logic [3:0] x, input logic [3:0] y);
        @(posedge clk); #1;
        start = 1'b1; dst_x = x; dst_y = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input logic exp_done, input logic [1:0] exp_code);
        for (int i = 0; i < 400; i++) begin
            if (done || err) break;
            @(posedge clk); #1;
        end
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, "_err"}, {31'd0, err}, {31'd0, !exp_done});
        check({tag, "_code"}, {30'd0, err_code}, {30'd0, exp_code});
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_idle"}, {30'd0, busy, step_valid}, 32'd0);
        check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    endtask

    // Read responder: returns the addressed cell rd_lat cycles after rd_en.
    initial begin
        int          cnt;
        logic [3:0]  lx, ly;
        cnt = 0; lx = 4'd0; ly = 4'd0;
        rd_valid = 1'b0; rd_cost = 12'd0; rd_dir = 3'd0;
        forever begin
            @(posedge clk); #1;
            rd_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rd_valid = 1'b1;
                    rd_cost  = cost_mem[lx][ly];
                    rd_dir   = dir_mem[lx][ly];
                end
            end
            if (rd_en) begin
                cnt = rd_lat; lx = rd_x; ly = rd_y;
            end
        end
    end

    // Ready driver: 0 = held high, 1 = toggling, otherwise held low.
    initial begin
        step_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       step_ready = 1'b1;
                1:       step_ready = !step_ready;
                default: step_ready = 1'b0;
            endcase
        end
    end

    // Beat monitor: scoreboard compare on handshake, payload hold during stalls.
    logic       held_v = 1'b0;
    logic [8:0] held_p = 9'd0;
    always @(negedge clk) begin
        logic [9:0] exp_b;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v)
                check("stall_hold", {22'd0, step_valid, step_x, step_y, step_last}, {22'd0, 1'b1, held_p});
            if (step_valid && step_ready) begin
                exp_b = (sb_q.size() > 0) ? {1'b1, sb_q.pop_front()} : 10'd0;
                check("beat", {22'd0, 1'b1, step_x, step_y, step_last}, {22'd0, exp_b});
            end
            held_v = step_valid && !step_ready;
            held_p = {step_x, step_y, step_last};
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic quiet;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; dst_x = 4'd0; dst_y = 4'd0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {8'd0, rd_en, step_valid, step_last, busy, done, err, err_code,
                             rd_x, rd_y, step_x, step_y}, 32'd0);
        rst_n = 1'b1;

        // Straight westward path, plus a start pulse while busy.
        clear_mem();
        for (int i = 1; i <= 5; i++) begin
            cost_mem[i][0] = 12'(2 * i);
            dir_mem[i][0]  = 3'd6;
        end
        cost_mem[0][0] = 12'd0;
        for (int i = 5; i >= 0; i--) push_beat(4'(i), 4'd0, (i == 0));
        kick(4'd5, 4'd0);
        repeat (4) @(posedge clk);
        #1;
        check("busy_mid", {31'd0, busy}, 32'd1);
        start = 1'b1; dst_x = 4'd9; dst_y = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end("straight", 1'b1, 2'd0);

        // Diagonal path under toggling backpressure.
        clear_mem();
        cost_mem[3][3] = 12'd9; dir_mem[3][3] = 3'd7;
        cost_mem[2][2] = 12'd6; dir_mem[2][2] = 3'd7;
        cost_mem[1][1] = 12'd3; dir_mem[1][1] = 3'd7;
        cost_mem[0][0] = 12'd0;
        push_beat(4'd3, 4'd3, 1'b0);
        push_beat(4'd2, 4'd2, 1'b0);
        push_beat(4'd1, 4'd1, 1'b0);
        push_beat(4'd0, 4'd0, 1'b1);
        ready_mode = 1;
        kick(4'd3, 4'd3);
        wait_end("diag", 1'b1, 2'd0);
        ready_mode = 0;

        // Unreached destination.
        clear_mem();
        kick(4'd7, 4'd7);
        wait_end("unreached", 1'b0, 2'd1);

        // Step westward off the grid edge.
        clear_mem();
        cost_mem[0][4] = 12'd5; dir_mem[0][4] = 3'd6;
        push_beat(4'd0, 4'd4, 1'b0);
        kick(4'd0, 4'd4);
        wait_end("offgrid", 1'b0, 2'd2);

        // Equal-cost neighbours pointing at each other.
        clear_mem();
        cost_mem[2][2] = 12'd5; dir_mem[2][2] = 3'd2;
        cost_mem[3][2] = 12'd5; dir_mem[3][2] = 3'd6;
        push_beat(4'd2, 4'd2, 1'b0);
        kick(4'd2, 4'd2);
        wait_end("loop", 1'b0, 2'd3);

        // Abort while waiting for read data; data arrives after the abort.
        clear_mem();
        cost_mem[6][6] = 12'd0;
        rd_lat = 2;
        kick(4'd6, 4'd6);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rd_en) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("abort_rd_en_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", {30'd0, busy, step_valid}, 32'd0);
        quiet = 1'b0;
        for (int i = 0; i < 6; i++) begin
            quiet = quiet | done | err | busy | step_valid;
            @(posedge clk); #1;
        end
        check("abort_quiet", {31'd0, quiet}, 32'd0);
        rd_lat = 1;

        // Start and abort together: start must be dropped.
        start = 1'b1; abort = 1'b1; dst_x = 4'd6; dst_y = 4'd6;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_drop", {30'd0, busy, rd_en}, 32'd0);

        // Reset asserted while a beat is stalled.
        clear_mem();
        cost_mem[8][8] = 12'd4; dir_mem[8][8] = 3'd0;
        ready_mode = 2;
        kick(4'd8, 4'd8);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (step_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("rst_emit_seen", {31'd0, seen}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_emit", {29'd0, step_valid, busy, rd_en}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", {30'd0, busy, step_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
